// File: rtl/sync_reg_arb.sv
// sync_reg_arb: round-robin arbiter feeding one shared single-entry CDC
// register crossing. Each requester has a one-deep holding register. Issues
// are paced by a holdoff counter and then by the crossing's busy flag.
// Optional build macro SYNC_REG_ARB_PRIO_EN: requester 0 gets fixed top
// priority, and the round-robin pointer rotates only among 1..N-1.
module sync_reg_arb #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int HOLDOFF = 4,
  localparam int IDW    = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic                 ch_busy,
  output logic                 ch_strobe,
  output logic [IDW+WIDTH-1:0] ch_data,
  output logic [N-1:0]         pend,
  output logic [N-1:0]         drop
);

  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [IDW-1:0]           rr_q;
  logic [N-1:0][WIDTH-1:0]  hold_q;
  logic [N-1:0]             pend_q;
  logic [N-1:0]             drop_q;
  logic                     ch_strobe_q;
  logic [IDW+WIDTH-1:0]     ch_data_q;

  logic                     any_pend;
  logic [IDW-1:0]           win;
  logic [IDW-1:0]           rr_d;
  logic [N-1:0]             cand;
  logic [IDW-1:0]           idx_w;
  int                       idx;

  // Winner selection: first pending entry at or above the rr pointer, wrapping.
  always_comb begin
    any_pend = 1'b0;
    win      = '0;
    cand     = pend_q;
    idx      = 0;
    idx_w    = '0;
`ifdef SYNC_REG_ARB_PRIO_EN
    // Requester 0 preempts the rotation; the scan below never sees bit 0.
    cand[0] = 1'b0;
    if (pend_q[0]) any_pend = 1'b1;
`endif
    for (int o = 0; o < N; o++) begin
      idx   = (int'(rr_q) + o) % N;
      idx_w = IDW'(idx);
      if (!any_pend && cand[idx_w]) begin
        any_pend = 1'b1;
        win      = idx_w;
      end
    end
    rr_d = (int'(win) + 1 == N) ? '0 : IDW'(int'(win) + 1);
`ifdef SYNC_REG_ARB_PRIO_EN
    // Grants to requester 0 leave the rotation where it was.
    if (win == '0) rr_d = rr_q;
`endif
  end

  // Capture, arbitration and issue pacing; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
      ch_strobe_q <= 1'b0;
      ch_data_q   <= '0;
    end else begin
      ch_strobe_q <= 1'b0;
      // A strobe coinciding with its own grant is not a drop: the old value
      // leaves on this edge and the new one stays pending.
      for (int i = 0; i < N; i++) begin
        drop_q[i] <= 1'b0;
        if (req[i]) begin
          hold_q[i] <= req_data[i*WIDTH +: WIDTH];
          pend_q[i] <= 1'b1;
          drop_q[i] <= pend_q[i] &&
                       !(state_q == S_IDLE && any_pend && win == IDW'(i));
        end else if (state_q == S_IDLE && any_pend && win == IDW'(i)) begin
          pend_q[i] <= 1'b0;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (any_pend) begin
            ch_strobe_q <= 1'b1;
            ch_data_q   <= {win, hold_q[win]};
            rr_q        <= rr_d;
            cnt_q       <= CW'(HOLDOFF);
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // ch_busy lags the strobe by a cycle, so it is only trusted at cnt==0.
          if (cnt_q != '0)   cnt_q   <= cnt_q - 1'b1;
          else if (!ch_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_strobe = ch_strobe_q;
  assign ch_data   = ch_data_q;
  assign pend      = pend_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_sync_reg_arb.sv
// Directed bench for sync_reg_arb (N=4, WIDTH=16, HOLDOFF=4). Expected issues
// are queued when the stimulus is driven and popped at each ch_strobe.
module tb_sync_reg_arb;

  localparam int N = 4, W = 16, HO = 4, IDW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*W-1:0]     req_data = '0;
  logic               ch_busy = 1'b0;
  logic               ch_strobe;
  logic [IDW+W-1:0]   ch_data;
  logic [N-1:0]       pend;
  logic [N-1:0]       drop;

  int checks = 0, errors = 0;
  int cyc = 0, n_strobe = 0, drop_total = 0;
  logic [IDW+W-1:0] sb[$];

  sync_reg_arb #(.N(N), .WIDTH(W), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ch_busy(ch_busy),
    .ch_strobe(ch_strobe), .ch_data(ch_data), .pend(pend), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && ch_strobe) begin
      n_strobe++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("issue", 64'(ch_data), 64'(sb.pop_front()));
    end
    if (!rst && drop != '0) begin
      drop_total++;
      chk("drop_id", 64'(drop), 64'h2);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    req[i] = 1'b1;
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_strobe(output int c, input int bound);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (ch_strobe) begin c = cyc; break; end
    end
    chk("strobe_seen", 64'(c >= 0), 64'd1);
  endtask

  initial begin
    int s0, s1, s2, s3, c, ns;
    // Reset state
    #3;
    chk("rst_strobe", 64'(ch_strobe), 64'd0);
    chk("rst_data",   64'(ch_data),   64'd0);
    chk("rst_pend",   64'(pend),      64'd0);
    chk("rst_drop",   64'(drop),      64'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Round-robin from rr=0: ids 0..3, spacing HOLDOFF+2
    for (int i = 0; i < N; i++) begin
      set_req(i, 16'h1111 * (i + 1));
      sb.push_back({IDW'(i), 16'(16'h1111 * (i + 1))});
    end
    tick();
    req = '0;
    chk("rr_pend_all", 64'(pend), 64'hF);
    wait_strobe(s0, 5);
    wait_strobe(s1, 20);
    wait_strobe(s2, 20);
    wait_strobe(s3, 20);
    chk("rr_gap01", 64'(s1 - s0), 64'd6);
    chk("rr_gap12", 64'(s2 - s1), 64'd6);
    chk("rr_gap23", 64'(s3 - s2), 64'd6);
    repeat (10) tick();

    // Busy extension; rr back at 0 so id 0 beats id 3
    set_req(0, 16'h00A0); set_req(3, 16'h00A3);
    sb.push_back({2'd0, 16'h00A0});
    sb.push_back({2'd3, 16'h00A3});
    tick();
    req = '0;
    wait_strobe(s0, 5);
    tick();
    ch_busy = 1'b1;
    repeat (10) tick();
    ch_busy = 1'b0;
    wait_strobe(c, 20);
    chk("busy_release", 64'(c - s0), 64'd13);
    repeat (10) tick();

    // Single issue latency
    set_req(2, 16'hBEEF);
    sb.push_back({2'd2, 16'hBEEF});
    tick();
    req = '0;
    chk("single_pend",   64'(pend),      64'h4);
    chk("single_nostrb", 64'(ch_strobe), 64'd0);
    tick();
    chk("single_strobe", 64'(ch_strobe), 64'd1);
    chk("single_data",   64'(ch_data),   64'({2'd2, 16'hBEEF}));
    chk("single_pclr",   64'(pend),      64'd0);
    repeat (10) tick();

    // Overwrite while requester 0 holds the crossing
    set_req(0, 16'h0123);
    sb.push_back({2'd0, 16'h0123});
    tick();
    req = '0;
    tick();
    chk("ow_strobe0", 64'(ch_strobe), 64'd1);
    set_req(1, 16'hAAAA);
    tick();
    req = '0;
    chk("ow_nodrop", 64'(drop), 64'd0);
    tick();
    set_req(1, 16'hBBBB);
    sb.push_back({2'd1, 16'hBBBB});
    tick();
    req = '0;
    chk("ow_drop", 64'(drop), 64'h2);
    tick();
    chk("ow_drop_1cyc", 64'(drop), 64'd0);
    wait_strobe(c, 20);
    repeat (12) tick();

    // Coincident strobe on the grant edge
    set_req(3, 16'h0005);
    sb.push_back({2'd3, 16'h0005});
    tick();
    set_req(3, 16'h0006);
    sb.push_back({2'd3, 16'h0006});
    tick();
    req = '0;
    chk("co_strobe", 64'(ch_strobe), 64'd1);
    chk("co_pend",   64'(pend),      64'h8);
    chk("co_nodrop", 64'(drop),      64'd0);
    wait_strobe(c, 20);
    repeat (12) tick();

    // Async reset mid-HOLD with 1 and 2 still pending
    set_req(0, 16'h0C00); set_req(1, 16'h0C01); set_req(2, 16'h0C02);
    sb.push_back({2'd0, 16'h0C00});
    tick();
    req = '0;
    tick();
    tick();
    chk("mr_pend", 64'(pend), 64'h6);
    #2 rst = 1'b1;
    #1;
    chk("mr_strobe", 64'(ch_strobe), 64'd0);
    chk("mr_data",   64'(ch_data),   64'd0);
    chk("mr_pend0",  64'(pend),      64'd0);
    chk("mr_drop",   64'(drop),      64'd0);
    tick();
    rst = 1'b0;
    ns = n_strobe;
    repeat (20) tick();
    chk("mr_quiet", 64'(n_strobe - ns), 64'd0);
    set_req(1, 16'h7777);
    sb.push_back({2'd1, 16'h7777});
    tick();
    req = '0;
    wait_strobe(c, 5);
    repeat (12) tick();

`ifdef SYNC_REG_ARB_PRIO_EN
    // Requester 0 wins over a pending requester 2 every time
    set_req(0, 16'hF000); set_req(2, 16'hF002);
    sb.push_back({2'd0, 16'hF000});
    tick();
    req = '0;
    wait_strobe(c, 5);
    set_req(0, 16'hF010);
    sb.push_back({2'd0, 16'hF010});
    tick();
    req = '0;
    sb.push_back({2'd2, 16'hF002});
    wait_strobe(c, 20);
    wait_strobe(c, 20);
    repeat (12) tick();
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("drop_total", 64'(drop_total), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
